// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet iteration controller.
package maxnet_pkg;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LW = 2;
  localparam int CW = 3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_ADD  = 3'd3,
    S_RELU = 3'd4,
    S_CAPT = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [1:0] RES_WIN     = 2'b00;
  localparam logic [1:0] RES_ZERO    = 2'b01;
  localparam logic [1:0] RES_TIMEOUT = 2'b10;
endpackage

// File: rtl/maxnet_nz_detect.sv
// Counts non-zero lanes of a PLU result vector and reports the lowest non-zero lane.
module maxnet_nz_detect
  import maxnet_pkg::*;
(
  input  logic [N-1:0][W-1:0] i_words,
  output logic [CW-1:0]       o_cnt,
  output logic [LW-1:0]       o_idx
);
  logic [N-1:0] w_nz;

  for (genvar j = 0; j < N; j++) begin : g_lane
    assign w_nz[j] = |i_words[j];
  end

  // Scan high to low so the lowest set lane is the last one written.
  always_comb begin
    o_cnt = '0;
    o_idx = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_nz[j]) begin
        o_cnt = o_cnt + CW'(1);
        o_idx = LW'(j);
      end
    end
  end
endmodule

// File: rtl/maxnet_iter_ctrl.sv
// Maxnet iteration controller: sequences PLU stage enables, captures ReLU results, detects termination.
module maxnet_iter_ctrl
  import maxnet_pkg::*;
#(
  parameter int MAX_ITER = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N-1:0][W-1:0] init_act,
  input  logic [N-1:0][W-1:0] plu_res,
  output logic [N-1:0][W-1:0] a_bus,
  output logic                w_we,
  output logic                a_we,
  output logic                r1_we,
  output logic                r2_we,
  output logic                r3_we,
  output logic                busy,
  output logic                done,
  output logic [LW-1:0]       winner,
  output logic [1:0]          result,
  output logic [7:0]          iter_cnt
);
  localparam logic [7:0] LP_MAX = 8'(MAX_ITER);

  state_t              r_state;
  logic [N-1:0][W-1:0] r_act;
  logic                r_first;
  logic [7:0]          r_iter;
  logic [LW-1:0]       r_win;
  logic [1:0]          r_res;
  logic [CW-1:0]       w_cnt;
  logic [LW-1:0]       w_idx;

  maxnet_nz_detect u_nz (
    .i_words (plu_res),
    .o_cnt   (w_cnt),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_act   <= '0;
      r_first <= 1'b0;
      r_iter  <= '0;
      r_win   <= '0;
      r_res   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) begin
          r_act   <= init_act;
          r_iter  <= '0;
          r_first <= 1'b1;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_first <= 1'b0;
          r_state <= S_MUL;
        end
        S_MUL:  r_state <= S_ADD;
        S_ADD:  r_state <= S_RELU;
        S_RELU: r_state <= S_CAPT;
        // Winner/zero checks outrank timeout so a last-iteration winner reports RES_WIN.
        S_CAPT: begin
          r_act  <= plu_res;
          r_iter <= r_iter + 8'd1;
          if (w_cnt == CW'(1)) begin
            r_win   <= w_idx;
            r_res   <= RES_WIN;
            r_state <= S_DONE;
          end else if (w_cnt == '0) begin
            r_win   <= '0;
            r_res   <= RES_ZERO;
            r_state <= S_DONE;
          end else if (r_iter + 8'd1 == LP_MAX) begin
            r_win   <= '0;
            r_res   <= RES_TIMEOUT;
            r_state <= S_DONE;
          end else begin
            r_state <= S_LOAD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a_bus    = r_act;
  assign w_we     = (r_state == S_LOAD) && r_first;
  assign a_we     = (r_state == S_LOAD);
  assign r1_we    = (r_state == S_MUL);
  assign r2_we    = (r_state == S_ADD);
  assign r3_we    = (r_state == S_RELU);
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done     = (r_state == S_DONE);
  assign winner   = r_win;
  assign result   = r_res;
  assign iter_cnt = r_iter;
endmodule

// File: tb/tb_maxnet_iter_ctrl.sv
// Bench for maxnet_iter_ctrl: the bench plays the PLU stub and compares against a per-iteration reference model.
module tb_maxnet_iter_ctrl;
  typedef logic [3:0][31:0] vec_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start3 = 1'b0;
  vec_t init_act = '0, plu_res = '0;

  vec_t a_bus, a_bus3;
  logic w_we, a_we, r1_we, r2_we, r3_we, busy, done;
  logic w_we3, a_we3, r1_we3, r2_we3, r3_we3, busy3, done3;
  logic [1:0] winner, result, winner3, result3;
  logic [7:0] iter_cnt, iter_cnt3;

  maxnet_iter_ctrl #(.MAX_ITER(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_act(init_act), .plu_res(plu_res),
    .a_bus(a_bus), .w_we(w_we), .a_we(a_we), .r1_we(r1_we), .r2_we(r2_we), .r3_we(r3_we),
    .busy(busy), .done(done), .winner(winner), .result(result), .iter_cnt(iter_cnt));

  maxnet_iter_ctrl #(.MAX_ITER(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .init_act(init_act), .plu_res(plu_res),
    .a_bus(a_bus3), .w_we(w_we3), .a_we(a_we3), .r1_we(r1_we3), .r2_we(r2_we3), .r3_we(r3_we3),
    .busy(busy3), .done(done3), .winner(winner3), .result(result3), .iter_cnt(iter_cnt3));

  always #5 clk = ~clk;

  bit sel = 1'b0;
  vec_t m_bus;
  logic [4:0] m_en;
  logic m_busy, m_done;
  logic [1:0] m_win, m_res;
  logic [7:0] m_iter;
  assign m_bus  = sel ? a_bus3 : a_bus;
  assign m_en   = sel ? {w_we3, a_we3, r1_we3, r2_we3, r3_we3} : {w_we, a_we, r1_we, r2_we, r3_we};
  assign m_busy = sel ? busy3 : busy;
  assign m_done = sel ? done3 : done;
  assign m_win  = sel ? winner3 : winner;
  assign m_res  = sel ? result3 : result;
  assign m_iter = sel ? iter_cnt3 : iter_cnt;

  int n_chk = 0, n_pass = 0;
  vec_t sq[$];  // PLU stub returns sq[i] at capture i; last entry repeats

  function automatic vec_t mk(input logic [31:0] a0, a1, a2, a3);
    vec_t v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    return v;
  endfunction

  function automatic int clip(input int i);
    return (i < sq.size()) ? i : sq.size() - 1;
  endfunction

  // Reference: walk the capture sequence applying the termination rules.
  task automatic model(input int maxi, output int iters, output logic [1:0] res, output logic [1:0] win);
    vec_t v;
    int nz, first;
    iters = 0; res = 2'b10; win = 2'd0;
    for (int i = 0; i < 300; i++) begin
      v = sq[clip(i)];
      nz = 0; first = -1;
      for (int j = 0; j < 4; j++)
        if (v[j] != 32'd0) begin
          nz++;
          if (first < 0) first = j;
        end
      iters = i + 1;
      if (nz == 1) begin res = 2'b00; win = 2'(first); return; end
      if (nz == 0) begin res = 2'b01; win = 2'd0; return; end
      if (iters == maxi) begin res = 2'b10; win = 2'd0; return; end
    end
  endtask

  task automatic run_comp(input vec_t init, input bit use3, input int pulse_c, input bit hold_start);
    int iters, last_c, k;
    logic [1:0] eres, ewin;
    logic [4:0] een;
    vec_t ebus;
    bit running;
    sel = use3;
    model(use3 ? 3 : 64, iters, eres, ewin);
    last_c = 5 * iters + 1;
    @(negedge clk);
    init_act = init;
    if (use3) start3 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start3 = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      if (c > 1) @(negedge clk);
      k = (c - 1) / 5;
      plu_res = sq[clip(k)];
      if (pulse_c == c) begin
        init_act = ~init;
        if (use3) start3 = 1'b1; else start = 1'b1;
      end else if (pulse_c + 1 == c) begin
        start = 1'b0; start3 = 1'b0;
      end
      if (hold_start && c == last_c) begin
        init_act = init;
        if (use3) start3 = 1'b1; else start = 1'b1;
      end
      running = (c <= 5 * iters);
      case ((c - 1) % 5)
        0: een = {(c == 1), 4'b1000};
        1: een = 5'b00100;
        2: een = 5'b00010;
        3: een = 5'b00001;
        default: een = 5'b00000;
      endcase
      if (!running) een = 5'b00000;
      ebus = (k == 0) ? init : sq[clip(k - 1)];
      n_chk++;
      if (m_en !== een) $display("FAIL enables c=%0d got=%b exp=%b", c, m_en, een);
      else n_pass++;
      n_chk++;
      if (m_busy !== running) $display("FAIL busy c=%0d got=%b exp=%b", c, m_busy, running);
      else n_pass++;
      n_chk++;
      if (m_done !== (c == last_c)) $display("FAIL done c=%0d got=%b exp=%b", c, m_done, (c == last_c));
      else n_pass++;
      n_chk++;
      if (m_iter !== 8'((k < iters) ? k : iters)) $display("FAIL iter_cnt c=%0d got=%0d exp=%0d", c, m_iter, (k < iters) ? k : iters);
      else n_pass++;
      n_chk++;
      if (m_bus !== ebus) $display("FAIL a_bus c=%0d got=%h exp=%h", c, m_bus, ebus);
      else n_pass++;
      if (c == last_c) begin
        n_chk++;
        if (m_res !== eres) $display("FAIL result got=%b exp=%b", m_res, eres);
        else n_pass++;
        n_chk++;
        if (m_win !== ewin) $display("FAIL winner got=%0d exp=%0d", m_win, ewin);
        else n_pass++;
      end
    end
    @(negedge clk);
    n_chk++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) $display("FAIL post_done done=%b busy=%b exp=0,0", m_done, m_busy);
    else n_pass++;
    if (hold_start) begin
      @(negedge clk);
      n_chk++;
      if (m_en !== 5'b11000 || m_iter !== 8'd0 || m_bus !== init)
        $display("FAIL restart en=%b iter=%0d bus=%h exp=11000,0,%h", m_en, m_iter, m_bus, init);
      else n_pass++;
      start = 1'b0; start3 = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_chk++;
    if ({a_bus, w_we, a_we, r1_we, r2_we, r3_we, busy, done, winner, result, iter_cnt} !== '0 ||
        {a_bus3, w_we3, a_we3, r1_we3, r2_we3, r3_we3, busy3, done3, winner3, result3, iter_cnt3} !== '0)
      $display("FAIL reset_state outputs not all zero bus=%h iter=%0d busy=%b", a_bus, iter_cnt, busy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    sq = '{mk(4, 0, 0, 0)};
    run_comp(mk(5, 1, 1, 1), 1'b0, 0, 1'b0);
  endtask

  task automatic test_multi;
    sq = '{mk(4, 2, 0, 3), mk(3, 1, 0, 2), mk(2, 0, 0, 1), mk(0, 0, 0, 1)};
    run_comp(mk(7, 3, 1, 5), 1'b0, 0, 1'b0);
  endtask

  task automatic test_all_zero;
    sq = '{mk(2, 2, 2, 2), mk(0, 0, 0, 0)};
    run_comp(mk(3, 3, 3, 3), 1'b0, 0, 1'b0);
  endtask

  task automatic test_timeout;
    sq = '{mk(1, 1, 0, 0)};
    run_comp(mk(9, 9, 0, 0), 1'b1, 0, 1'b0);
  endtask

  task automatic test_start_ignored;
    sq = '{mk(4, 2, 0, 3), mk(3, 1, 0, 2), mk(0, 0, 32'h8000_0000, 0)};
    run_comp(mk(6, 2, 1, 4), 1'b0, 2, 1'b0);
  endtask

  task automatic test_random;
    vec_t v;
    int len;
    bit u3;
    for (int r = 0; r < 24; r++) begin
      sq.delete();
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        for (int j = 0; j < 4; j++)
          case ($urandom_range(0, 5))
            0, 1, 2: v[j] = 32'd0;
            3:       v[j] = 32'd1;
            4:       v[j] = 32'h8000_0000;
            default: v[j] = $urandom;
          endcase
        sq.push_back(v);
      end
      u3 = ($urandom_range(0, 3) == 0);
      run_comp(vec_t'({$urandom, $urandom, $urandom, $urandom}), u3, 0, 1'b0);
    end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back;
    sq = '{mk(0, 0, 5, 0)};
    run_comp(mk(1, 2, 3, 4), 1'b0, 0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid;
    sel = 1'b0;
    sq = '{mk(1, 1, 1, 1)};
    @(negedge clk);
    init_act = mk(8, 8, 8, 8);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (r2_we !== 1'b1) $display("FAIL mid_reset_setup r2_we=%b exp=1", r2_we);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({a_bus, w_we, a_we, r1_we, r2_we, r3_we, busy, done, winner, result, iter_cnt} !== '0)
      $display("FAIL mid_reset outputs bus=%h en=%b busy=%b win=%0d res=%b iter=%0d exp=all0",
               a_bus, {w_we, a_we, r1_we, r2_we, r3_we}, busy, winner, result, iter_cnt);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL after_reset c=%0d done=%b busy=%b exp=0,0", c, done, busy);
      else n_pass++;
    end
    sq = '{mk(0, 3, 0, 0)};
    run_comp(mk(2, 3, 4, 5), 1'b0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_all_zero();
    test_timeout();
    test_start_ignored();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/maxnet_iter_ctrl.md
# maxnet_iter_ctrl

Iteration controller sitting directly downstream of (and wrapped around) the four-lane PLU datapath in the Maxnet engine. It broadcasts the current activation vector to the PLUs and sequences their stage enables (weight/activation load, multiply, add, ReLU). It captures the four ReLU results as the next activation vector and repeats until exactly one activation is non-zero, all are zero, or an iteration limit is hit. It then reports the winner index and a result code to the top-level host logic.

## Interface
- `N`, 4: number of neurons / PLU lanes (fixed 4 in this revision; lane index width 2).
- `W`, 32: activation / PLU result word width.
- `MAX_ITER`, 64: maximum iterations before timeout (1..255).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a competition; sampled only in IDLE.
- `init_act`  in  N*W  initial activations, lane j at bits [j*W +: W]; sampled on accepted `start`.
- `plu_res`  in  N*W  registered ReLU outputs of the four PLUs (lane j = PLU j).
- `a_bus`  out  N*W  activation vector driven to every PLU's a1..a4 inputs.
- `w_we`  out  1  PLU weight-register load enable.
- `a_we`  out  1  PLU activation-register load enable.
- `r1_we`, `r2_we`, `r3_we`  out  1 each  PLU pipeline-stage enables (product, partial sum, ReLU).
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `winner`  out  2  index of surviving neuron; held until next accepted `start`.
- `result`  out  2  00 = single winner, 01 = all zero, 10 = timeout; held like `winner`.
- `iter_cnt`  out  8  completed iterations; held like `winner`.

## Operation
- States: IDLE, LOAD, MUL, ADD, RELU, CAPT, DONE.
- IDLE: `start`=1 -> latch `init_act` into internal `act` registers, clear `iter_cnt`, set first-iteration flag, go LOAD. `start` is ignored in all other states.
- LOAD: `a_we`=1. `w_we`=1 only when the first-iteration flag is set, then clear the flag. Go MUL.
- MUL: `r1_we`=1 -> ADD. ADD: `r2_we`=1 -> RELU. RELU: `r3_we`=1 -> CAPT.
- CAPT: `plu_res` is valid. Copy into `act`, increment `iter_cnt`, compute nz = popcount of lanes where word != 0 (full bit pattern compared).
  - nz==1: `winner` = that lane, `result`=00, go DONE.
  - nz==0: `winner`=0, `result`=01, go DONE.
  - nz>=2 and `iter_cnt`+1 == MAX_ITER: `winner`=0, `result`=10, go DONE.
  - otherwise: go LOAD.
  - The nz tests take priority over timeout, so a winner found on the last iteration reports 00.
- DONE: `done`=1 for one cycle, `busy` drops, go IDLE.
- `a_bus` is a continuous copy of `act`. The stage enables are decoded from state and are mutually exclusive.
- The block does no arithmetic on activations. Weights (1 on the diagonal, −ε elsewhere) are supplied to the PLUs by top-level logic and must be stable from `start` through the first LOAD.

## Timing
- Reset values: all outputs 0, `a_bus`=0, state IDLE, first-iteration flag 0.
- Asserting `rst_n` low mid-run (any state) returns to IDLE asynchronously. All enables drop at once. No `done` is issued.
- Start accepted at edge E0. LOAD is the cycle after E0. Each iteration is 5 cycles (LOAD..CAPT).
- `done` is high in cycle 5k+1 after E0 for k iterations. Example: a 1-iteration run gives `done` in cycle 6.
- `winner`/`result`/`iter_cnt` are updated at the CAPT edge, so they are valid when `done` is high, and stable until the next accepted `start`.
- `start` held high through DONE is accepted again in the following IDLE cycle.

## Structure
- Package `maxnet_pkg`: state enum, result code constants (`RES_WIN`, `RES_ZERO`, `RES_TIMEOUT`), `N`, `W`, lane index width.
- Sub-module `maxnet_nz_detect`: combinational. Input is N*W words; outputs are the 3-bit nonzero count and the lowest nonzero lane index.
- FSM, `act` registers, counter and output registers live in the top module.

## Test plan
- `init_act`=(5,1,1,1). Stub returns (4,0,0,0) in the first CAPT. Expect `done` in cycle 6 after start, `winner`=0, `result`=00, `iter_cnt`=1, `w_we` high exactly once.
- Stub sequence (4,2,0,3) -> (3,1,0,2) -> (2,0,0,1) -> (0,0,0,1). Expect 4 iterations, `done` in cycle 21, `winner`=3, `result`=00. `a_bus` equals the previous capture in each LOAD. `w_we` is low after iteration 1.
- Stub returns (2,2,2,2), then (0,0,0,0). Expect `result`=01, `winner`=0, `iter_cnt`=2.
- `MAX_ITER`=3, stub returns (1,1,0,0) forever. Expect `result`=10, `iter_cnt`=3, `done` in cycle 16.
- Pulse `start` during MUL of a run. Expect no effect on `iter_cnt` or timing.
- Drop `rst_n` during ADD. Expect all outputs 0 immediately, no `done`. A fresh `start` afterwards runs normally.
